// File: rtl/mem_access_serial_bridge_if.sv
// Signal bundle between the core's memory-access port, the bridge and external memory.
// The bridge connects through the slave modport; the core/memory side uses master.
interface mem_access_serial_bridge_if #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 128,
   parameter int SERIAL_W = 4
);
   logic [ADDR_W-1:0]   memAccessAddr;
   logic [DATA_W-1:0]   memAccessWriteData;
   logic                memAccessRE;
   logic                memAccessWE;
   logic                memAccessReadBusy;
   logic                memAccessWriteBusy;
   logic [SERIAL_W-1:0] nextMemReadSerial;
   logic [SERIAL_W-1:0] nextMemWriteSerial;
   logic                memReadDataReady;
   logic [DATA_W-1:0]   memReadData;
   logic [SERIAL_W-1:0] memReadSerial;
   logic                memAccessResponseValid;
   logic [SERIAL_W-1:0] memAccessResponseSerial;
   // extReq: transfer happens on a rising edge where extReqValid && extReqReady; once
   // valid is high the fields hold steady and valid never drops until that transfer.
   logic                extReqValid;
   logic                extReqReady;
   logic                extReqWrite;
   logic [ADDR_W-1:0]   extReqAddr;
   logic [DATA_W-1:0]   extReqData;
   logic                extRspValid;
   logic                extRspWrite;
   logic [DATA_W-1:0]   extRspData;
   logic                protocolError;

   modport slave (
      input  memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
             extReqReady, extRspValid, extRspWrite, extRspData,
      output memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
             memReadDataReady, memReadData, memReadSerial,
             memAccessResponseValid, memAccessResponseSerial,
             extReqValid, extReqWrite, extReqAddr, extReqData, protocolError
   );

   modport master (
      output memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
             extReqReady, extRspValid, extRspWrite, extRspData,
      input  memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
             memReadDataReady, memReadData, memReadSerial,
             memAccessResponseValid, memAccessResponseSerial,
             extReqValid, extReqWrite, extReqAddr, extReqData, protocolError
   );
endinterface

// File: rtl/mem_access_serial_bridge.sv
// One-entry request buffer between the core's memory-access port and external memory,
// with read/write serial numbering, outstanding-access tracking and in-order responses.
module mem_access_serial_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 128,
   parameter int SERIAL_W   = 4,
   parameter int MAX_READS  = 8,
   parameter int MAX_WRITES = 8
) (
   input  logic clk,
   input  logic rst,
   mem_access_serial_bridge_if.slave bus
);
   localparam int RD_CNT_W = $clog2(MAX_READS + 1);
   localparam int WR_CNT_W = $clog2(MAX_WRITES + 1);
   localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(MAX_READS);
   localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(MAX_WRITES);

   logic                buf_valid_q, buf_valid_d;
   logic                buf_write_q, buf_write_d;
   logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;
   logic                rd_busy_q, rd_busy_d;
   logic                wr_busy_q, wr_busy_d;
   logic [SERIAL_W-1:0] next_rd_ser_q, next_rd_ser_d;
   logic [SERIAL_W-1:0] next_wr_ser_q, next_wr_ser_d;
   logic [RD_CNT_W-1:0] rd_out_q, rd_out_d;
   logic [WR_CNT_W-1:0] wr_out_q, wr_out_d;
   logic [SERIAL_W-1:0] rsp_rd_ser_q, rsp_rd_ser_d;
   logic [SERIAL_W-1:0] rsp_wr_ser_q, rsp_wr_ser_d;
   logic                rd_pulse_q, rd_pulse_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [SERIAL_W-1:0] rd_serial_q, rd_serial_d;
   logic                wr_pulse_q, wr_pulse_d;
   logic [SERIAL_W-1:0] wr_serial_q, wr_serial_d;
   logic                err_q, err_d;

   logic rd_acc, wr_acc, conflict;
   logic rd_rsp_ok, rd_rsp_bad, wr_rsp_ok, wr_rsp_bad;

   always_comb begin
      // A read wins over a simultaneous write; the write is dropped and flagged.
      rd_acc     = bus.memAccessRE && !rd_busy_q;
      wr_acc     = bus.memAccessWE && !wr_busy_q && !rd_acc;
      conflict   = rd_acc && bus.memAccessWE && !wr_busy_q;
      rd_rsp_ok  = bus.extRspValid && !bus.extRspWrite && (rd_out_q != '0);
      rd_rsp_bad = bus.extRspValid && !bus.extRspWrite && (rd_out_q == '0);
      wr_rsp_ok  = bus.extRspValid &&  bus.extRspWrite && (wr_out_q != '0);
      wr_rsp_bad = bus.extRspValid &&  bus.extRspWrite && (wr_out_q == '0);

      buf_valid_d   = buf_valid_q;
      buf_write_d   = buf_write_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      next_rd_ser_d = next_rd_ser_q;
      next_wr_ser_d = next_wr_ser_q;
      rd_out_d      = rd_out_q;
      wr_out_d      = wr_out_q;
      rsp_rd_ser_d  = rsp_rd_ser_q;
      rsp_wr_ser_d  = rsp_wr_ser_q;
      rd_pulse_d    = rd_rsp_ok;
      rd_data_d     = rd_data_q;
      rd_serial_d   = rd_serial_q;
      wr_pulse_d    = wr_rsp_ok;
      wr_serial_d   = wr_serial_q;
      err_d         = err_q | conflict | rd_rsp_bad | wr_rsp_bad;

      if (buf_valid_q && bus.extReqReady) buf_valid_d = 1'b0;
      if (rd_acc || wr_acc) begin
         buf_valid_d = 1'b1;
         buf_write_d = wr_acc;
         buf_addr_d  = bus.memAccessAddr;
         buf_data_d  = bus.memAccessWriteData;
      end

      if (rd_acc) next_rd_ser_d = next_rd_ser_q + SERIAL_W'(1);
      if (wr_acc) next_wr_ser_d = next_wr_ser_q + SERIAL_W'(1);

      if (rd_acc && !rd_rsp_ok)      rd_out_d = rd_out_q + RD_CNT_W'(1);
      else if (!rd_acc && rd_rsp_ok) rd_out_d = rd_out_q - RD_CNT_W'(1);
      if (wr_acc && !wr_rsp_ok)      wr_out_d = wr_out_q + WR_CNT_W'(1);
      else if (!wr_acc && wr_rsp_ok) wr_out_d = wr_out_q - WR_CNT_W'(1);

      if (rd_rsp_ok) begin
         rd_data_d    = bus.extRspData;
         rd_serial_d  = rsp_rd_ser_q;
         rsp_rd_ser_d = rsp_rd_ser_q + SERIAL_W'(1);
      end
      if (wr_rsp_ok) begin
         wr_serial_d  = rsp_wr_ser_q;
         rsp_wr_ser_d = rsp_wr_ser_q + SERIAL_W'(1);
      end

      // Busy is registered from next-state so it already covers this cycle's accept/drain.
      rd_busy_d = buf_valid_d || (rd_out_d == RD_MAX);
      wr_busy_d = buf_valid_d || (wr_out_d == WR_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_q   <= 1'b0;
         buf_write_q   <= 1'b0;
         buf_addr_q    <= '0;
         buf_data_q    <= '0;
         rd_busy_q     <= 1'b0;
         wr_busy_q     <= 1'b0;
         next_rd_ser_q <= '0;
         next_wr_ser_q <= '0;
         rd_out_q      <= '0;
         wr_out_q      <= '0;
         rsp_rd_ser_q  <= '0;
         rsp_wr_ser_q  <= '0;
         rd_pulse_q    <= 1'b0;
         rd_data_q     <= '0;
         rd_serial_q   <= '0;
         wr_pulse_q    <= 1'b0;
         wr_serial_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         buf_valid_q   <= buf_valid_d;
         buf_write_q   <= buf_write_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         rd_busy_q     <= rd_busy_d;
         wr_busy_q     <= wr_busy_d;
         next_rd_ser_q <= next_rd_ser_d;
         next_wr_ser_q <= next_wr_ser_d;
         rd_out_q      <= rd_out_d;
         wr_out_q      <= wr_out_d;
         rsp_rd_ser_q  <= rsp_rd_ser_d;
         rsp_wr_ser_q  <= rsp_wr_ser_d;
         rd_pulse_q    <= rd_pulse_d;
         rd_data_q     <= rd_data_d;
         rd_serial_q   <= rd_serial_d;
         wr_pulse_q    <= wr_pulse_d;
         wr_serial_q   <= wr_serial_d;
         err_q         <= err_d;
      end
   end

   assign bus.memAccessReadBusy       = rd_busy_q;
   assign bus.memAccessWriteBusy      = wr_busy_q;
   assign bus.nextMemReadSerial       = next_rd_ser_q;
   assign bus.nextMemWriteSerial      = next_wr_ser_q;
   assign bus.memReadDataReady        = rd_pulse_q;
   assign bus.memReadData             = rd_data_q;
   assign bus.memReadSerial           = rd_serial_q;
   assign bus.memAccessResponseValid  = wr_pulse_q;
   assign bus.memAccessResponseSerial = wr_serial_q;
   assign bus.extReqValid             = buf_valid_q;
   assign bus.extReqWrite             = buf_write_q;
   assign bus.extReqAddr              = buf_addr_q;
   assign bus.extReqData              = buf_data_q;
   assign bus.protocolError           = err_q;
endmodule

// File: tb/tb_mem_access_serial_bridge.sv
// Bench for mem_access_serial_bridge: directed scenarios plus a random phase, all checked
// against a counting model of accepted requests, outstanding accesses and serial numbers.
module tb_mem_access_serial_bridge;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 128;
   localparam int SERIAL_W = 4;
   localparam int MAX_RD   = 8;
   localparam int MAX_WR   = 8;
   localparam int REQ_W    = 1 + ADDR_W + DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_access_serial_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SERIAL_W(SERIAL_W)) bus ();

   mem_access_serial_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SERIAL_W(SERIAL_W),
      .MAX_READS(MAX_RD), .MAX_WRITES(MAX_WR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic [REQ_W-1:0]           req_exp_q[$];
   logic [SERIAL_W+DATA_W-1:0] rd_exp_q[$];
   logic [SERIAL_W-1:0]        wr_exp_q[$];

   int                  m_rd_out, m_wr_out;
   logic [SERIAL_W-1:0] m_rd_ser, m_wr_ser, m_rsp_rd_ser, m_rsp_wr_ser;
   logic                m_err;
   int                  ready_mode = 1; // 0: held low, 1: held high, 2: random

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       bus.extReqReady = 1'b0;
         1:       bus.extReqReady = 1'b1;
         default: bus.extReqReady = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Scoreboard: every transfer and response pulse must match the head of its queue.
   always @(negedge clk) begin : monitor
      logic [REQ_W-1:0]           e;
      logic [SERIAL_W+DATA_W-1:0] r;
      if (rst && bus.extReqValid && bus.extReqReady) begin
         if (req_exp_q.size() == 0) chk("req_unexpected", 1, 0);
         else begin
            e = req_exp_q.pop_front();
            chk("req_write", bus.extReqWrite, e[REQ_W-1]);
            chk("req_addr", bus.extReqAddr, e[ADDR_W+DATA_W-1:DATA_W]);
            if (e[REQ_W-1]) chk("req_data", bus.extReqData, e[DATA_W-1:0]);
         end
      end
      if (rst && bus.memReadDataReady) begin
         if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            r = rd_exp_q.pop_front();
            chk("rd_serial", bus.memReadSerial, r[SERIAL_W+DATA_W-1:DATA_W]);
            chk("rd_data", bus.memReadData, r[DATA_W-1:0]);
         end
      end
      if (rst && bus.memAccessResponseValid) begin
         if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
         else chk("wr_serial", bus.memAccessResponseSerial, wr_exp_q.pop_front());
      end
   end

   task automatic model_clear();
      m_rd_out = 0; m_wr_out = 0;
      m_rd_ser = '0; m_wr_ser = '0; m_rsp_rd_ser = '0; m_rsp_wr_ser = '0;
      m_err = 1'b0;
      req_exp_q.delete(); rd_exp_q.delete(); wr_exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_rd_busy", bus.memAccessReadBusy, 0);
      chk("rst_wr_busy", bus.memAccessWriteBusy, 0);
      chk("rst_next_rd", bus.nextMemReadSerial, 0);
      chk("rst_next_wr", bus.nextMemWriteSerial, 0);
      chk("rst_rd_rdy", bus.memReadDataReady, 0);
      chk("rst_rd_data", bus.memReadData, 0);
      chk("rst_rd_ser", bus.memReadSerial, 0);
      chk("rst_wr_vld", bus.memAccessResponseValid, 0);
      chk("rst_wr_ser", bus.memAccessResponseSerial, 0);
      chk("rst_req_vld", bus.extReqValid, 0);
      chk("rst_req_wr", bus.extReqWrite, 0);
      chk("rst_req_addr", bus.extReqAddr, 0);
      chk("rst_req_data", bus.extReqData, 0);
      chk("rst_err", bus.protocolError, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
      int n = 0;
      while (((rd && bus.memAccessReadBusy) || (wr && bus.memAccessWriteBusy)) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         chk("busy_timeout", 1, 0);
         return;
      end
      bus.memAccessAddr      = addr;
      bus.memAccessWriteData = data;
      bus.memAccessRE        = rd;
      bus.memAccessWE        = wr;
      if (rd) begin
         req_exp_q.push_back({1'b0, addr, data});
         m_rd_ser++;
         m_rd_out++;
         if (wr) m_err = 1'b1;
      end else if (wr) begin
         req_exp_q.push_back({1'b1, addr, data});
         m_wr_ser++;
         m_wr_out++;
      end
      @(negedge clk);
      bus.memAccessRE = 1'b0;
      bus.memAccessWE = 1'b0;
      chk("next_rd_ser", bus.nextMemReadSerial, m_rd_ser);
      chk("next_wr_ser", bus.nextMemWriteSerial, m_wr_ser);
      chk("acc_rd_busy", bus.memAccessReadBusy, 1);
      chk("acc_wr_busy", bus.memAccessWriteBusy, 1);
      chk("acc_err", bus.protocolError, m_err);
   endtask

   task automatic send_rsp(input bit wr, input logic [DATA_W-1:0] data);
      bit exp_pulse = 1'b0;
      bus.extRspValid = 1'b1;
      bus.extRspWrite = wr;
      bus.extRspData  = data;
      if (!wr && m_rd_out > 0) begin
         rd_exp_q.push_back({m_rsp_rd_ser, data});
         m_rsp_rd_ser++;
         m_rd_out--;
         exp_pulse = 1'b1;
      end else if (wr && m_wr_out > 0) begin
         wr_exp_q.push_back(m_rsp_wr_ser);
         m_rsp_wr_ser++;
         m_wr_out--;
         exp_pulse = 1'b1;
      end else m_err = 1'b1;
      @(negedge clk);
      bus.extRspValid = 1'b0;
      chk(wr ? "wr_pulse" : "rd_pulse",
          wr ? bus.memAccessResponseValid : bus.memReadDataReady, exp_pulse);
      chk(wr ? "wr_no_rd_pulse" : "rd_no_wr_pulse",
          wr ? bus.memReadDataReady : bus.memAccessResponseValid, 0);
      chk("rsp_err", bus.protocolError, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.memAccessAddr = '0; bus.memAccessWriteData = '0;
      bus.memAccessRE = 1'b0; bus.memAccessWE = 1'b0;
      bus.extRspValid = 1'b0; bus.extRspWrite = 1'b0; bus.extRspData = '0;
      @(negedge clk);
      do_reset();
      @(negedge clk);
      chk("idle_rd_busy", bus.memAccessReadBusy, 0);
      chk("idle_wr_busy", bus.memAccessWriteBusy, 0);
      chk("idle_next_rd", bus.nextMemReadSerial, 0);
      chk("idle_req_vld", bus.extReqValid, 0);

      // Single read: request visible one cycle after acceptance, data back one after extRsp.
      issue(1, 0, 32'h1000, '0);
      chk("t1_req_vld", bus.extReqValid, 1);
      chk("t1_req_wr", bus.extReqWrite, 0);
      chk("t1_req_addr", bus.extReqAddr, 32'h1000);
      repeat (3) @(negedge clk);
      send_rsp(0, 128'hAB);
      chk("t6_rd_data", bus.memReadData, 128'hAB);
      chk("t6_rd_ser", bus.memReadSerial, 0);

      // Fill the read window.
      for (int i = 0; i < MAX_RD; i++) issue(1, 0, $urandom(), '0);
      repeat (2) @(negedge clk);
      chk("full_rd_busy", bus.memAccessReadBusy, 1);
      chk("full_wr_busy", bus.memAccessWriteBusy, 0);
      chk("full_next_rd", bus.nextMemReadSerial, m_rd_ser);
      send_rsp(0, rand_data());
      chk("unfull_rd_busy", bus.memAccessReadBusy, 0);
      while (m_rd_out > 0) send_rsp(0, rand_data());

      // Stalled write: fields hold while ready is low.
      ready_mode = 0;
      @(negedge clk);
      issue(0, 1, 32'hCAFE_0040, 128'h1234_5678_9ABC_DEF0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_vld", bus.extReqValid, 1);
         chk("stall_wr", bus.extReqWrite, 1);
         chk("stall_addr", bus.extReqAddr, 32'hCAFE_0040);
         chk("stall_data", bus.extReqData, 128'h1234_5678_9ABC_DEF0);
         chk("stall_rd_busy", bus.memAccessReadBusy, 1);
         chk("stall_wr_busy", bus.memAccessWriteBusy, 1);
         @(negedge clk);
      end
      ready_mode = 1;
      repeat (2) @(negedge clk);
      send_rsp(1, '0);
      chk("wr_ack_ser0", bus.memAccessResponseSerial, 0);

      // Serial wrap across 17 read/response pairs.
      for (int i = 0; i < 17; i++) begin
         issue(1, 0, $urandom(), '0);
         @(negedge clk);
         send_rsp(0, rand_data());
      end
      chk("wrap_next_rd", bus.nextMemReadSerial, m_rd_ser);
      chk("wrap_err", bus.protocolError, 0);

      // Simultaneous RE/WE, then a stray write response.
      @(negedge clk);
      issue(1, 1, 32'h2000, rand_data());
      @(negedge clk);
      send_rsp(0, rand_data());
      send_rsp(1, '0);
      chk("stray_err", bus.protocolError, 1);

      // Random traffic with random backpressure.
      ready_mode = 2;
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 3))
            0: if (m_rd_out < MAX_RD) issue(1, 0, $urandom(), rand_data());
            1: if (m_wr_out < MAX_WR) issue(0, 1, $urandom(), rand_data());
            2: if (m_rd_out > 0) send_rsp(0, rand_data());
            default: if (m_wr_out > 0) send_rsp(1, '0);
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      ready_mode = 1;
      repeat (4) @(negedge clk);
      while (m_rd_out > 0) send_rsp(0, rand_data());
      while (m_wr_out > 0) send_rsp(1, '0);
      @(negedge clk);
      chk("end_req_q", req_exp_q.size(), 0);
      chk("end_rd_q", rd_exp_q.size(), 0);
      chk("end_wr_q", wr_exp_q.size(), 0);
      chk("end_rd_busy", bus.memAccessReadBusy, 0);
      chk("end_next_wr", bus.nextMemWriteSerial, m_wr_ser);

      // Reset with a request parked in the buffer; its late response is then stray.
      ready_mode = 0;
      @(negedge clk);
      issue(1, 0, 32'h3000, '0);
      do_reset();
      ready_mode = 1;
      @(negedge clk);
      chk("post_rst_vld", bus.extReqValid, 0);
      send_rsp(0, rand_data());
      chk("late_rsp_err", bus.protocolError, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
